// File: rtl/ring_lock_pkg.sv
// Shared types and default widths for the receiver-ring thermal lock controller.
package ring_lock_pkg;

    localparam int DEFAULT_BIT_WIDTH   = 8;
    localparam int DEFAULT_WINDOW_LOG2 = 6;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_MEASURE,
        ST_UPDATE
    } lock_state_t;

    typedef enum logic {
        DIR_UP   = 1'b0,
        DIR_DOWN = 1'b1
    } dir_t;

    function automatic dir_t flip_dir(input dir_t d);
        return (d == DIR_UP) ? DIR_DOWN : DIR_UP;
    endfunction

endpackage

// File: rtl/ring_lock_if.sv
// Sample/decision bus between the receiver and the lock controller, plus the heater drive outputs.
interface ring_lock_if
    import ring_lock_pkg::*;
#(
    parameter int BIT_WIDTH   = DEFAULT_BIT_WIDTH,
    parameter int WINDOW_LOG2 = DEFAULT_WINDOW_LOG2
);
    logic                   lock_en;
    logic                   sample_valid;
    logic                   sample_bit;
    logic                   ref_bit;
    logic [BIT_WIDTH-1:0]   heater_code;
    logic                   heater_pdm;
    logic                   locked;
    logic [WINDOW_LOG2:0]   err_count;

    modport master (
        output lock_en, sample_valid, sample_bit, ref_bit,
        input  heater_code, heater_pdm, locked, err_count
    );

    modport slave (
        input  lock_en, sample_valid, sample_bit, ref_bit,
        output heater_code, heater_pdm, locked, err_count
    );
endinterface

// File: rtl/pdm_modulator.sv
// First-order pulse-density modulator: the carry of a free-running accumulator
// is high exactly `code` times in every 2^BIT_WIDTH cycles.
module pdm_modulator #(
    parameter int BIT_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [BIT_WIDTH-1:0] code,
    output logic                 pdm
);
    logic [BIT_WIDTH-1:0] acc;
    logic [BIT_WIDTH:0]   sum;

    assign sum = {1'b0, acc} + {1'b0, code};

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            acc <= '0;
            pdm <= 1'b0;
        end else begin
            acc <= sum[BIT_WIDTH-1:0];
            pdm <= sum[BIT_WIDTH];
        end
    end
endmodule

// File: rtl/ring_lock_ctrl.sv
// Hill-climbing heater lock loop: counts decision errors per window and steps the heater code.
// Optional macro RING_LOCK_PDM_EN compiles in the pulse-density heater drive.
module ring_lock_ctrl
    import ring_lock_pkg::*;
#(
    parameter int BIT_WIDTH   = DEFAULT_BIT_WIDTH,
    parameter int WINDOW_LOG2 = DEFAULT_WINDOW_LOG2,
    parameter int STEP        = 1,
    parameter int HEATER_INIT = 0
) (
    input  logic       clk,
    input  logic       rst_n,
    ring_lock_if.slave bus
);
    localparam logic [BIT_WIDTH-1:0]   CODE_INIT   = BIT_WIDTH'(HEATER_INIT);
    localparam logic [BIT_WIDTH:0]     STEP_EXT    = (BIT_WIDTH+1)'(STEP);
    localparam logic [BIT_WIDTH-1:0]   CODE_MAX    = {BIT_WIDTH{1'b1}};
    localparam logic [WINDOW_LOG2:0]   WINDOW_FULL = {1'b1, {WINDOW_LOG2{1'b0}}};
    localparam logic [WINDOW_LOG2-1:0] LAST_SAMPLE = {WINDOW_LOG2{1'b1}};

    lock_state_t            state, state_nxt;
    dir_t                   dir, dir_nxt;
    logic [BIT_WIDTH-1:0]   code, code_nxt;
    logic [WINDOW_LOG2-1:0] sample_cnt;
    logic [WINDOW_LOG2:0]   err_cnt;
    logic [WINDOW_LOG2:0]   err_prev;
    logic [WINDOW_LOG2:0]   err_count_q;
    logic                   locked_q;
    logic                   mismatch;
    logic [BIT_WIDTH:0]     up_sum;
    logic                   down_under;

    assign mismatch   = bus.sample_bit ^ bus.ref_bit;
    assign up_sum     = {1'b0, code} + STEP_EXT;
    assign down_under = {1'b0, code} < STEP_EXT;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        if (!bus.lock_en) begin
            state_nxt = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE:    state_nxt = ST_MEASURE;
                ST_MEASURE: if (bus.sample_valid && sample_cnt == LAST_SAMPLE) state_nxt = ST_UPDATE;
                ST_UPDATE:  state_nxt = ST_MEASURE;
                default:    state_nxt = ST_IDLE;
            endcase
        end
    end

    // A worse window than the last one reverses direction; hitting a rail clamps and reverses for next time.
    always_comb begin
        dir_nxt  = (err_cnt > err_prev) ? flip_dir(dir) : dir;
        code_nxt = code;
        if (dir_nxt == DIR_UP) begin
            if (up_sum[BIT_WIDTH]) begin
                code_nxt = CODE_MAX;
                dir_nxt  = DIR_DOWN;
            end else begin
                code_nxt = up_sum[BIT_WIDTH-1:0];
            end
        end else begin
            if (down_under) begin
                code_nxt = '0;
                dir_nxt  = DIR_UP;
            end else begin
                code_nxt = code - STEP_EXT[BIT_WIDTH-1:0];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            code        <= CODE_INIT;
            dir         <= DIR_UP;
            sample_cnt  <= '0;
            err_cnt     <= '0;
            err_prev    <= WINDOW_FULL;
            err_count_q <= '0;
            locked_q    <= 1'b0;
        end else if (!bus.lock_en) begin
            sample_cnt <= '0;
            err_cnt    <= '0;
            err_prev   <= WINDOW_FULL;
            locked_q   <= 1'b0;
        end else begin
            case (state)
                ST_MEASURE: begin
                    if (bus.sample_valid) begin
                        sample_cnt <= sample_cnt + 1'b1;
                        err_cnt    <= err_cnt + {{WINDOW_LOG2{1'b0}}, mismatch};
                    end
                end
                ST_UPDATE: begin
                    err_count_q <= err_cnt;
                    err_prev    <= err_cnt;
                    sample_cnt  <= '0;
                    err_cnt     <= '0;
                    if (err_cnt == '0) begin
                        locked_q <= 1'b1;
                    end else begin
                        locked_q <= 1'b0;
                        code     <= code_nxt;
                        dir      <= dir_nxt;
                    end
                end
                default: begin
                    sample_cnt <= '0;
                    err_cnt    <= '0;
                end
            endcase
        end
    end

    assign bus.heater_code = code;
    assign bus.locked      = locked_q;
    assign bus.err_count   = err_count_q;

`ifdef RING_LOCK_PDM_EN
    logic pdm_w;

    pdm_modulator #(
        .BIT_WIDTH(BIT_WIDTH)
    ) u_pdm (
        .clk  (clk),
        .rst_n(rst_n),
        .code (code),
        .pdm  (pdm_w)
    );

    assign bus.heater_pdm = pdm_w;
`else
    assign bus.heater_pdm = 1'b0;
`endif

endmodule
